// File: rtl/loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package loader_pkg;

  // Loader frame states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam int         MAX_LEN         = 128;
  localparam int         TIMEOUT_CYC_DEF = 65535;

  // Width needed to hold the value cyc (at least one bit).
  function automatic int timer_width(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

  localparam int TIMER_W = timer_width(TIMEOUT_CYC_DEF);

  // A frame length is usable when it is 1..MAX_LEN.
  function automatic logic len_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(MAX_LEN));
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream and instruction-memory write port of the program loader.
// The slave modport is the loader's view, the master modport the environment's.
interface prog_loader_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] inst_address;
  logic [7:0]        inst_data;
  logic              inst_we;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, inst_address, inst_data, inst_we
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, inst_address, inst_data, inst_we
  );
endinterface

// File: rtl/loader_timer.sv
// Idle-cycle counter: clears on clr_i, counts up while en_i, saturates at
// TIMEOUT_CYC and flags expired_o while sitting at that value.
module loader_timer
  import loader_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int           W     = timer_width(TIMEOUT_CYC);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYC);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LIMIT);
endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: frames SYNC, LEN, N data bytes (and a check
// byte when LOADER_CHECK_EN is defined), writes the data bytes to instruction
// memory from address 0 and holds the core in reset until a good load.
// Optional feature macro: LOADER_CHECK_EN (XOR check byte after the data).
module prog_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.slave  bus,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef LOADER_CHECK_EN
  logic [7:0]        acc_q, acc_d;
`endif

  logic fire_s;
  logic in_frame_s;
  logic expired_s;

  assign fire_s     = bus.rx_valid & rx_ready_q;
  assign in_frame_s = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CHK);

  // Idle timer runs only inside a frame and restarts on every accepted byte.
  loader_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (fire_s | ~in_frame_s),
    .en_i      (in_frame_s & ~fire_s),
    .expired_o (expired_s)
  );

  // Next-state and next-output logic; a byte arriving on the expiry cycle wins.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECK_EN
    acc_d   = acc_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (fire_s && (bus.rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
          addr_d  = '0;
`ifdef LOADER_CHECK_EN
          acc_d   = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN: begin
        if (fire_s) begin
          if (len_ok(bus.rx_data)) begin
            cnt_d   = bus.rx_data;
            state_d = ST_DATA;
          end else begin
            state_d = ST_ERR;
          end
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        if (fire_s) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = bus.rx_data;
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q - 8'd1;
`ifdef LOADER_CHECK_EN
          acc_d   = acc_q ^ bus.rx_data;
          state_d = (cnt_q == 8'd1) ? ST_CHK : ST_DATA;
`else
          state_d = (cnt_q == 8'd1) ? ST_DONE : ST_DATA;
`endif
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef LOADER_CHECK_EN
      ST_CHK: begin
        if (fire_s) begin
          state_d = (bus.rx_data == acc_q) ? ST_DONE : ST_ERR;
        end else if (expired_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_CHK;
        end
      end
`endif
      default: state_d = ST_ERR;
    endcase
  end

  // Status outputs follow the state being entered so they line up with it.
  always_comb begin
    busy_d      = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
    done_d      = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERR);
    cpu_rst_n_d = (state_d == ST_DONE);
    rx_ready_d  = ~we_d;
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= 8'd0;
      rx_ready_q  <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= 8'd0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECK_EN
      acc_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      rx_ready_q  <= rx_ready_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef LOADER_CHECK_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign bus.rx_ready     = rx_ready_q;
  assign bus.inst_we      = we_q;
  assign bus.inst_address = waddr_q;
  assign bus.inst_data    = wdata_q;
  assign cpu_rst_n        = cpu_rst_n_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes and frame
// outcomes, a negedge monitor pops and compares them as the DUT produces them.
module tb_prog_loader;
  localparam int AW = 7;
  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_rst_n, busy, done, err;

  prog_loader_if #(.ADDR_W(AW)) bus ();

  prog_loader #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        wr_q[$];
  bit         res_q[$];   // 1 = frame expected good, 0 = expected error
  logic [7:0] payload[$];
  int         tests = 0;
  int         fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every write and every frame outcome against the queues.
  logic prev_we = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    if (bus.inst_we) begin
      chk("ready_low_during_write", {31'd0, bus.rx_ready}, 32'd0);
      chk("isolated_write", {31'd0, prev_we}, 32'd0);
      if (wr_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 bus.inst_address, bus.inst_data);
      end else begin
        wr_t e;
        e = wr_q.pop_front();
        chk("write_addr", {25'd0, bus.inst_address}, {25'd0, e.a});
        chk("write_data", {24'd0, bus.inst_data}, {24'd0, e.d});
      end
    end
    if ((done && !prev_done) || (err && !prev_err)) begin
      if (res_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got done %0d err %0d expected no outcome", done, err);
      end else begin
        bit e;
        e = res_q.pop_front();
        chk("result_done", {31'd0, done}, {31'd0, e});
        chk("result_err", {31'd0, err}, {31'd0, !e});
        chk("result_cpu_rst_n", {31'd0, cpu_rst_n}, {31'd0, e});
        chk("result_busy", {31'd0, busy}, 32'd0);
      end
    end
    prev_we   <= bus.inst_we;
    prev_done <= done;
    prev_err  <= err;
  end

  // Offer one byte; returns just after the edge where it was taken.
  task automatic send(input logic [7:0] b, input bit keep);
    int w;
    w = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      tests++;
      fails++;
      $display("FAIL send_wait: rx_ready stayed %0d for byte %0h, required 1", bus.rx_ready, b);
    end
    @(posedge clk);
    #1;
    if (!keep) bus.rx_valid = 1'b0;
  endtask

  // One frame built from payload; chk_val -1 = correct check byte,
  // -2 = corrupted check byte, >= 0 = that literal check byte.
  task automatic frame(input int n, input int chk_val, input bit keep);
    logic [7:0] acc, cb, nb;
    wr_t        e;
    acc = 8'h00;
    nb  = n[7:0];
    send(8'hA5, keep);
    if (n == 0 || n > 128) begin
      res_q.push_back(1'b0);
      send(nb, 1'b0);
      return;
    end
    send(nb, keep);
    for (int i = 0; i < n; i++) begin
      acc ^= payload[i];
      e.a = 7'(i);
      e.d = payload[i];
      wr_q.push_back(e);
`ifdef LOADER_CHECK_EN
      send(payload[i], keep);
`else
      if (i == n - 1) res_q.push_back(1'b1);
      send(payload[i], keep && (i != n - 1));
`endif
    end
`ifdef LOADER_CHECK_EN
    if (chk_val == -1)      cb = acc;
    else if (chk_val == -2) cb = ~acc;
    else                    cb = chk_val[7:0];
    res_q.push_back(cb == acc);
    send(cb, 1'b0);
`else
    if (chk_val < -2) $display("unused check selector %0d", chk_val);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
    chk({tag, "_inst_we"}, {31'd0, bus.inst_we}, 32'd0);
    chk({tag, "_inst_address"}, {25'd0, bus.inst_address}, 32'd0);
    chk({tag, "_inst_data"}, {24'd0, bus.inst_data}, 32'd0);
    chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    int   n;
    wr_t  e;
    logic [7:0] b;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    // Reset state.
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {31'd0, bus.rx_ready}, 32'd1);
    chk("cpu_rst_n_after_release", {31'd0, cpu_rst_n}, 32'd0);

    // Garbage in IDLE is dropped, then illegal lengths.
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    chk("idle_garbage_busy", {31'd0, busy}, 32'd0);
    chk("idle_garbage_done", {31'd0, done}, 32'd0);
    chk("idle_garbage_err", {31'd0, err}, 32'd0);
    payload.delete();
    frame(0, -1, 1'b0);
    repeat (2) @(negedge clk);
    chk("len0_err", {31'd0, err}, 32'd1);
    frame(129, -1, 1'b0);
    repeat (2) @(negedge clk);
    chk("len129_err", {31'd0, err}, 32'd1);

    // Basic three-byte load.
    payload = '{8'h13, 8'h05, 8'h67};
    frame(3, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk("basic_done", {31'd0, done}, 32'd1);
    chk("basic_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);

`ifdef LOADER_CHECK_EN
    // Wrong check byte, then recovery.
    frame(3, 0, 1'b0);
    repeat (3) @(negedge clk);
    chk("badchk_err", {31'd0, err}, 32'd1);
    chk("badchk_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    frame(3, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk("recover_done", {31'd0, done}, 32'd1);
    chk("recover_err", {31'd0, err}, 32'd0);
`endif

    // Maximum length frame.
    payload.delete();
    for (int i = 0; i < 128; i++) payload.push_back(8'(i));
    frame(128, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk("max_len_done", {31'd0, done}, 32'd1);

    // Continuous rx_valid during data plus random frames.
    for (int f = 0; f < 8; f++) begin
      n = (f == 5) ? int'($urandom_range(129, 255)) : int'($urandom_range(1, 24));
      payload.delete();
      for (int i = 0; i < n && i < 128; i++) payload.push_back(8'($urandom_range(0, 255)));
      frame(n, ($urandom_range(0, 3) == 0) ? -2 : -1, 1'b1);
      repeat (3) @(negedge clk);
    end

    // Idle timeout inside DATA.
    b = 8'($urandom_range(0, 255));
    e.a = 7'd0;
    e.d = b;
    wr_q.push_back(e);
    res_q.push_back(1'b0);
    send(8'hA5, 1'b0);
    send(8'h02, 1'b0);
    send(b, 1'b0);
    c = 0;
    while (!err && c < TO + 20) begin
      @(negedge clk);
      c++;
    end
    chk("timeout_window", {31'd0, (c >= TO && c <= TO + 3)}, 32'd1);

    // Reset in the middle of DATA.
    send(8'hA5, 1'b0);
    send(8'd10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom_range(0, 255));
      e.a = 7'(i);
      e.d = b;
      wr_q.push_back(e);
      send(b, 1'b0);
    end
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    chk("midreset_writes_seen", wr_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", {31'd0, busy}, 32'd0);
    chk("post_reset_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);

    // Fresh load after the abort.
    payload.delete();
    for (int i = 0; i < 5; i++) payload.push_back(8'($urandom_range(0, 255)));
    frame(5, -1, 1'b0);
    repeat (5) @(negedge clk);
    chk("final_done", {31'd0, done}, 32'd1);
    chk("writes_drained", wr_q.size(), 32'd0);
    chk("results_drained", res_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader that drives the core's instruction-memory write port (inst_address, inst_data, inst_we).
- Frames a host byte stream as SYNC, LEN, N data bytes and an optional check byte. It writes the data bytes to consecutive instruction addresses starting at 0.
- Holds the core in reset for the whole load and releases it only after a good load.
- Sits between the top-level input pins and the core.

Parameters:
- ADDR_W, 7, instruction-memory byte address width (max N = 2^ADDR_W = 128).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 65535, maximum idle cycles between bytes inside a frame before error.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid this cycle.
- rx_ready  out  1  loader accepts a byte this cycle; a transfer occurs when rx_valid & rx_ready.
- inst_address  out  ADDR_W  instruction-memory write address.
- inst_data  out  8  instruction-memory write byte.
- inst_we  out  1  one-cycle write strobe.
- cpu_rst_n  out  1  active-low reset to the core; low while loading.
- busy  out  1  frame in progress (LEN/DATA/CHK).
- done  out  1  last frame loaded good.
- err  out  1  last frame failed.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - rx_ready = 0 while rst_n is low; rx_ready = 1 from the first clk edge after release.
  - inst_address = 0, inst_data = 0, inst_we = 0.
  - cpu_rst_n = 0, busy = 0, done = 0, err = 0.
  - Byte counter = 0, check accumulator = 0, timer = 0.
- States: IDLE, LEN, DATA, CHK, DONE, ERR.
- IDLE:
  - A byte equal to SYNC_BYTE goes to LEN and clears the accumulator and address.
  - Any other byte is discarded.
- LEN:
  - The accepted byte is N.
  - N = 0 or N > 128 goes to ERR.
  - Otherwise the counter loads N and the state goes to DATA.
- DATA, for each accepted byte:
  - Next cycle: inst_we = 1, inst_data = byte, inst_address = current address.
  - The address then increments and wraps at 2^ADDR_W. The wrap is reachable only with N = 128, where the final address is 127.
  - The counter decrements.
  - The accumulator XORs in the byte.
  - After the N-th byte the state goes to CHK (or to DONE when the check feature is compiled out).
- Write pacing:
  - rx_ready = 0 in every cycle that inst_we = 1.
  - Data throughput is therefore at most 1 byte per 2 cycles; every write is a single isolated beat.
- Write latency: exactly 1 cycle from the accepted byte to inst_we.
- CHK: see Optional Feature.
- DONE:
  - done = 1 and cpu_rst_n = 1, starting the cycle after entry.
  - A SYNC_BYTE goes to LEN, clears done and drives cpu_rst_n = 0 the next cycle.
  - Other bytes are discarded.
- ERR:
  - err = 1; cpu_rst_n stays 0.
  - A SYNC_BYTE goes to LEN and clears err.
- Timeout:
  - In LEN, DATA and CHK the timer counts cycles with no transfer and resets on each transfer.
  - When the timer reaches TIMEOUT_CYC the state goes to ERR.
  - A transfer in the same cycle as expiry wins: the byte is taken and the timer resets.
- Other rules:
  - A SYNC_BYTE value inside LEN, DATA or CHK is treated as ordinary data, not a restart.
  - busy = 1 in LEN, DATA and CHK only.
  - Asserting rst_n mid-frame aborts immediately. All outputs return to reset values; memory already written is left as is.

Optional Feature:
- Macro: LOADER_CHECK_EN.
- Defined:
  - CHK state present; one byte is accepted there.
  - Byte == accumulator (XOR of all N data bytes) goes to DONE.
  - Otherwise goes to ERR.
- Undefined:
  - CHK and the accumulator are removed.
  - DATA goes straight to DONE after the N-th byte.

Decomposition:
- Package loader_pkg:
  - State enum (IDLE, LEN, DATA, CHK, DONE, ERR).
  - SYNC_BYTE default.
  - MAX_LEN = 128.
  - Timer width = $clog2(TIMEOUT_CYC+1).
- One sub-module, loader_timer: the resettable idle-cycle counter with clear, enable and expired outputs.

Test Plan:
1. Reset, then A5, 03, 13, 05, 67 with checks on; the check byte is 13^05^67 = 71, so send 71 -> inst_we pulses write addr 0/13, 1/05, 2/67 (each 1 cycle after the byte); DONE; cpu_rst_n = 1; done = 1.
2. Same frame with check byte 00 -> err = 1, cpu_rst_n = 0; then a new A5 frame -> err clears and the load succeeds.
3. Bytes 00, 00, FF in IDLE -> no writes, state stays IDLE; then A5, 00 -> ERR. Separately, A5, 81 -> ERR.
4. A5, 80, then 128 bytes of 00..7F, then the check byte -> final write at addr 127 with data 7F; addr wraps to 0; DONE.
5. Hold rx_valid = 1 continuously during DATA -> rx_ready alternates 1/0; no two consecutive inst_we cycles.
6. Timeout and reset checks:
   - A5, 02, one byte, then silence for TIMEOUT_CYC cycles -> ERR at expiry.
   - Separately, assert rst_n mid-DATA -> all outputs at reset values at once, with no further writes.
